// File: rtl/mux_rr_sched.sv
//------------------------------------------------------------------------------
// Module   : mux_rr_sched
// Purpose  : Round-robin, burst-capped scheduler driving a shared 4:1 mux.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_rr_sched #(
    parameter int BURST = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [3:0]       gnt,
    output logic [1:0]       Sel,
    output logic [WIDTH-1:0] F,
    output logic             F_valid,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

    state_t           state;
    logic [1:0]       ptr;
    logic [3:0]       cnt;
    logic [1:0]       base;
    logic [1:0]       pick;
    logic             any_req;
    logic             release_now;
    logic [WIDTH-1:0] chan;

    // On release the search restarts just past the owner, so the registered
    // Sel (the owner) directly provides the next search base.
    always_comb begin
        base = (state == GRANT) ? (Sel + 2'd1) : ptr;
        pick = base;
        for (int i = 3; i >= 0; i--) begin
            if (req[base + 2'(i)]) begin
                pick = base + 2'(i);
            end
        end
        any_req     = |req;
        release_now = !req[Sel] || (cnt == CNT_LAST);
        case (Sel)
            2'd0:    chan = A;
            2'd1:    chan = B;
            2'd2:    chan = C;
            default: chan = D;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            cnt     <= 4'd0;
            gnt     <= 4'd0;
            Sel     <= 2'd0;
            F       <= '0;
            F_valid <= 1'b0;
        end else begin
            F_valid <= (state == GRANT);
            if (state == GRANT) begin
                F <= chan;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << pick;
                        Sel   <= pick;
                        cnt   <= 4'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr <= Sel + 2'd1;
                        if (any_req) begin
                            gnt <= 4'b0001 << pick;
                            Sel <= pick;
                            cnt <= 4'd0;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'd0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == GRANT);

endmodule

`default_nettype wire
